// File: rtl/vadd_pkg.sv
// Shared defaults and beat typedefs for the vector-add operand path.
// Lane k of a beat occupies bits [k*ELEM_W +: ELEM_W].
package vadd_pkg;

    localparam int VADD_PE     = 8;
    localparam int VADD_ELEM_W = 8;

    typedef logic [VADD_ELEM_W-1:0] lane_t;
    typedef lane_t [VADD_PE-1:0]    beat_t;

    function automatic int data_w(input int pe, input int elem_w);
        return pe * elem_w;
    endfunction

endpackage

// File: rtl/vadd_stream_fifo.sv
// First-word-fall-through stream FIFO: head visible the cycle after the push edge.
// A full FIFO refuses input even if it pops in the same cycle; push_rdy_o is low during reset.
module vadd_stream_fifo #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int LVL_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld_i,
    input  logic [WIDTH-1:0] push_dat_i,
    output logic             push_rdy_o,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_dat_o,
    output logic [LVL_W-1:0] lvl_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic             push;
    logic             pop;

    assign push_rdy_o = ~rst & (lvl_q != LVL_W'(DEPTH));
    assign push       = push_vld_i & push_rdy_o;
    // Pop is qualified locally so a stray request on an empty FIFO cannot corrupt the count.
    assign pop        = pop_i & (lvl_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        lvl_d    = lvl_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   lvl_d = lvl_q + LVL_W'(1);
            2'b01:   lvl_d = lvl_q - LVL_W'(1);
            default: lvl_d = lvl_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lvl_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lvl_q    <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat_i;
        end
    end

    assign head_dat_o = mem_q[rd_ptr_q];
    assign lvl_o      = lvl_q;

endmodule

// File: rtl/vector_add_input_aligner.sv
// Aligns two skewed operand streams into one lock-stepped pair; 1-cycle latency, 1 pair/cycle.
// Each producer is backpressured only by its own FIFO filling; the pair pops only when both outputs are accepted.
module vector_add_input_aligner
    import vadd_pkg::*;
#(
    parameter  int PE     = VADD_PE,
    parameter  int ELEM_W = VADD_ELEM_W,
    parameter  int DEPTH  = 4,
    localparam int DATA_W = data_w(PE, ELEM_W),
    localparam int LVL_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s0_TDATA,
    input  logic              s0_TVALID,
    output logic              s0_TREADY,
    input  logic [DATA_W-1:0] s1_TDATA,
    input  logic              s1_TVALID,
    output logic              s1_TREADY,
    output logic [DATA_W-1:0] in0_V_data_V_TDATA,
    output logic              in0_V_data_V_TVALID,
    input  logic              in0_V_data_V_TREADY,
    output logic [DATA_W-1:0] in1_V_data_V_TDATA,
    output logic              in1_V_data_V_TVALID,
    input  logic              in1_V_data_V_TREADY,
    output logic [LVL_W-1:0]  lvl0,
    output logic [LVL_W-1:0]  lvl1,
    output logic              skew_err
);

    logic pair_v;
    logic pair_pop;
    logic split_acc;
    logic skew_err_q, skew_err_d;

    vadd_stream_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (s0_TVALID),
        .push_dat_i (s0_TDATA),
        .push_rdy_o (s0_TREADY),
        .pop_i      (pair_pop),
        .head_dat_o (in0_V_data_V_TDATA),
        .lvl_o      (lvl0)
    );

    vadd_stream_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk        (clk),
        .rst        (rst),
        .push_vld_i (s1_TVALID),
        .push_dat_i (s1_TDATA),
        .push_rdy_o (s1_TREADY),
        .pop_i      (pair_pop),
        .head_dat_o (in1_V_data_V_TDATA),
        .lvl_o      (lvl1)
    );

    assign pair_v    = (lvl0 != '0) & (lvl1 != '0);
    assign pair_pop  = pair_v & in0_V_data_V_TREADY & in1_V_data_V_TREADY;
    // A one-sided accept means the adder consumed an operand with no partner: flag it, never pop.
    assign split_acc = pair_v & (in0_V_data_V_TREADY ^ in1_V_data_V_TREADY);

    assign skew_err_d = skew_err_q | split_acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skew_err_q <= 1'b0;
        end else begin
            skew_err_q <= skew_err_d;
        end
    end

    assign in0_V_data_V_TVALID = pair_v;
    assign in1_V_data_V_TVALID = pair_v;
    assign skew_err            = skew_err_q;

endmodule

// File: tb/tb_vector_add_input_aligner.sv
// Directed table plus streaming/random scoreboard phases for vector_add_input_aligner.
module tb_vector_add_input_aligner;
    import vadd_pkg::*;

    localparam int DEPTH  = 4;
    localparam int DATA_W = 64;
    localparam int NV     = 22;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] s0_TDATA, s1_TDATA;
    logic              s0_TVALID, s1_TVALID, s0_TREADY, s1_TREADY;
    logic [DATA_W-1:0] in0_V_data_V_TDATA, in1_V_data_V_TDATA;
    logic              in0_V_data_V_TVALID, in1_V_data_V_TVALID;
    logic              in0_V_data_V_TREADY, in1_V_data_V_TREADY;
    logic [2:0]        lvl0, lvl1;
    logic              skew_err;

    int checks   = 0;
    int failures = 0;
    int pair_cnt = 0;
    bit sb_en    = 1'b0;
    logic [DATA_W-1:0] q0[$];
    logic [DATA_W-1:0] q1[$];

    vector_add_input_aligner #(.PE(8), .ELEM_W(8), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .s0_TDATA            (s0_TDATA),
        .s0_TVALID           (s0_TVALID),
        .s0_TREADY           (s0_TREADY),
        .s1_TDATA            (s1_TDATA),
        .s1_TVALID           (s1_TVALID),
        .s1_TREADY           (s1_TREADY),
        .in0_V_data_V_TDATA  (in0_V_data_V_TDATA),
        .in0_V_data_V_TVALID (in0_V_data_V_TVALID),
        .in0_V_data_V_TREADY (in0_V_data_V_TREADY),
        .in1_V_data_V_TDATA  (in1_V_data_V_TDATA),
        .in1_V_data_V_TVALID (in1_V_data_V_TVALID),
        .in1_V_data_V_TREADY (in1_V_data_V_TREADY),
        .lvl0                (lvl0),
        .lvl1                (lvl1),
        .skew_err            (skew_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       s0v;
        logic [7:0] s0b;
        logic       s1v;
        logic [7:0] s1b;
        logic       r0;
        logic       r1;
        logic       ov;
        logic [7:0] d0b;
        logic [7:0] d1b;
        int         l0;
        int         l1;
        logic       s0r;
        logic       s1r;
        logic       sk;
    } vec_t;

    vec_t vecs [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rep(input logic [7:0] b);
        beat_t bt;
        for (int k = 0; k < VADD_PE; k++) bt[k] = b;
        return bt;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: handshakes sampled mid-cycle while inputs are stable.
    always @(negedge clk) begin
        if (sb_en && !rst) begin
            logic [63:0] e0, e1;
            if (s0_TVALID && s0_TREADY) q0.push_back(s0_TDATA);
            if (s1_TVALID && s1_TREADY) q1.push_back(s1_TDATA);
            check("lvl0_le_depth", 64'(lvl0 <= 3'(DEPTH)), 64'd1);
            check("lvl1_le_depth", 64'(lvl1 <= 3'(DEPTH)), 64'd1);
            if (in0_V_data_V_TVALID && in0_V_data_V_TREADY && in1_V_data_V_TREADY) begin
                pair_cnt++;
                if (q0.size() == 0 || q1.size() == 0) begin
                    check("sb_pair_without_input", 64'd1, 64'd0);
                end else begin
                    e0 = q0.pop_front();
                    e1 = q1.pop_front();
                    check("sb_in0_data", in0_V_data_V_TDATA, e0);
                    check("sb_in1_data", in1_V_data_V_TDATA, e1);
                end
            end
        end
    end

    initial begin
        logic acc0, acc1, rdy;

        // s0v s0b  s1v s1b  r0 r1  ov d0 d1  l0 l1 s0r s1r sk
        vecs[0]  = '{1'b1, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1, 0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 8'h02, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 2, 0, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{1'b1, 8'h03, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 3, 0, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 8'h00, 1'b1, 8'hA0, 1'b1, 1'b1, 1'b1, 8'h01, 8'hA0, 3, 1, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 8'hA1, 1'b1, 1'b1, 1'b1, 8'h02, 8'hA1, 2, 1, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1, 0, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 8'hA2, 1'b1, 1'b1, 1'b1, 8'h03, 8'hA2, 1, 1, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 0, 0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1, 0, 1'b1, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 2, 0, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 8'h12, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 3, 0, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 8'h13, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 4, 0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 8'h14, 1'b1, 8'hB0, 1'b0, 1'b0, 1'b1, 8'h10, 8'hB0, 4, 1, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 8'h14, 1'b1, 8'hB1, 1'b1, 1'b1, 1'b1, 8'h11, 8'hB1, 3, 1, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 8'h14, 1'b1, 8'hB2, 1'b1, 1'b1, 1'b1, 8'h12, 8'hB2, 3, 1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 8'hB3, 1'b1, 1'b1, 1'b1, 8'h13, 8'hB3, 2, 1, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 8'hB4, 1'b1, 1'b1, 1'b1, 8'h14, 8'hB4, 1, 1, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 0, 0, 1'b1, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 8'h20, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 8'h20, 8'hC0, 1, 1, 1'b1, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h20, 8'hC0, 1, 1, 1'b1, 1'b1, 1'b1};
        vecs[20] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h20, 8'hC0, 1, 1, 1'b1, 1'b1, 1'b1};
        vecs[21] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 0, 0, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        s0_TVALID = 1'b0; s0_TDATA = '0;
        s1_TVALID = 1'b0; s1_TDATA = '0;
        in0_V_data_V_TREADY = 1'b0;
        in1_V_data_V_TREADY = 1'b0;
        #2;
        check("rst_s0_tready_low", 64'(s0_TREADY), 64'd0);
        check("rst_s1_tready_low", 64'(s1_TREADY), 64'd0);
        step(); step(); step();
        rst = 1'b0;
        #1;
        check("idle_in0_valid", 64'(in0_V_data_V_TVALID), 64'd0);
        check("idle_in1_valid", 64'(in1_V_data_V_TVALID), 64'd0);
        check("idle_s0_tready", 64'(s0_TREADY), 64'd1);
        check("idle_s1_tready", 64'(s1_TREADY), 64'd1);
        check("idle_lvl0", 64'(lvl0), 64'd0);
        check("idle_lvl1", 64'(lvl1), 64'd0);
        check("idle_skew_err", 64'(skew_err), 64'd0);

        // Skew, full backpressure with wrap, split accept.
        for (int i = 0; i < NV; i++) begin
            s0_TVALID = vecs[i].s0v; s0_TDATA = rep(vecs[i].s0b);
            s1_TVALID = vecs[i].s1v; s1_TDATA = rep(vecs[i].s1b);
            in0_V_data_V_TREADY = vecs[i].r0;
            in1_V_data_V_TREADY = vecs[i].r1;
            step();
            check($sformatf("v%0d_in0_valid", i), 64'(in0_V_data_V_TVALID), 64'(vecs[i].ov));
            check($sformatf("v%0d_in1_valid", i), 64'(in1_V_data_V_TVALID), 64'(vecs[i].ov));
            check($sformatf("v%0d_lvl0", i), 64'(lvl0), 64'(vecs[i].l0));
            check($sformatf("v%0d_lvl1", i), 64'(lvl1), 64'(vecs[i].l1));
            check($sformatf("v%0d_s0_tready", i), 64'(s0_TREADY), 64'(vecs[i].s0r));
            check($sformatf("v%0d_s1_tready", i), 64'(s1_TREADY), 64'(vecs[i].s1r));
            check($sformatf("v%0d_skew_err", i), 64'(skew_err), 64'(vecs[i].sk));
            if (vecs[i].ov) begin
                check($sformatf("v%0d_in0_data", i), in0_V_data_V_TDATA, rep(vecs[i].d0b));
                check($sformatf("v%0d_in1_data", i), in1_V_data_V_TDATA, rep(vecs[i].d1b));
            end
        end

        // Mid-stream reset with lvl0=3 and a valid pair pending.
        in0_V_data_V_TREADY = 1'b0;
        in1_V_data_V_TREADY = 1'b0;
        s0_TVALID = 1'b1; s0_TDATA = rep(8'h30);
        s1_TVALID = 1'b1; s1_TDATA = rep(8'hD0);
        step();
        s1_TVALID = 1'b0;
        s0_TDATA = rep(8'h31);
        step();
        s0_TDATA = rep(8'h32);
        step();
        s0_TVALID = 1'b0;
        check("pre_rst_lvl0", 64'(lvl0), 64'd3);
        check("pre_rst_valid", 64'(in0_V_data_V_TVALID), 64'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_in0_valid", 64'(in0_V_data_V_TVALID), 64'd0);
        check("mid_rst_in1_valid", 64'(in1_V_data_V_TVALID), 64'd0);
        check("mid_rst_s0_tready", 64'(s0_TREADY), 64'd0);
        check("mid_rst_lvl0", 64'(lvl0), 64'd0);
        check("mid_rst_skew_err", 64'(skew_err), 64'd0);
        step(); step();
        rst = 1'b0;
        #1;
        check("post_rst_s0_tready", 64'(s0_TREADY), 64'd1);
        check("post_rst_s1_tready", 64'(s1_TREADY), 64'd1);
        check("post_rst_lvl1", 64'(lvl1), 64'd0);
        check("post_rst_valid", 64'(in1_V_data_V_TVALID), 64'd0);

        // Streaming: 64 beats each side, adder always ready.
        sb_en = 1'b1;
        pair_cnt = 0;
        in0_V_data_V_TREADY = 1'b1;
        in1_V_data_V_TREADY = 1'b1;
        for (int i = 0; i < 64; i++) begin
            s0_TVALID = 1'b1; s0_TDATA = {$urandom(), $urandom()};
            s1_TVALID = 1'b1; s1_TDATA = {$urandom(), $urandom()};
            step();
            check($sformatf("stream%0d_valid", i), 64'(in0_V_data_V_TVALID), 64'd1);
            check($sformatf("stream%0d_lvl0", i), 64'(lvl0), 64'd1);
            check($sformatf("stream%0d_lvl1", i), 64'(lvl1), 64'd1);
        end
        s0_TVALID = 1'b0;
        s1_TVALID = 1'b0;
        step();
        check("stream_pair_count", 64'(pair_cnt), 64'd64);
        check("stream_drained_lvl0", 64'(lvl0), 64'd0);

        // Random valid/ready with AXI-legal hold of unaccepted beats.
        acc0 = 1'b0;
        acc1 = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!s0_TVALID || acc0) begin
                s0_TVALID = ($urandom_range(0, 2) != 0);
                s0_TDATA  = {$urandom(), $urandom()};
            end
            if (!s1_TVALID || acc1) begin
                s1_TVALID = ($urandom_range(0, 3) == 0);
                s1_TDATA  = {$urandom(), $urandom()};
            end
            rdy = ($urandom_range(0, 3) != 0);
            in0_V_data_V_TREADY = rdy;
            in1_V_data_V_TREADY = rdy;
            acc0 = s0_TVALID & s0_TREADY;
            acc1 = s1_TVALID & s1_TREADY;
            step();
        end
        s0_TVALID = 1'b0;
        s1_TVALID = 1'b0;
        for (int i = 0; i < 120; i++) begin
            if (q0.size() > 0) begin
                s1_TVALID = 1'b1;
                s1_TDATA  = {$urandom(), $urandom()};
            end else begin
                s1_TVALID = 1'b0;
            end
            if (q1.size() > 0 && q0.size() == 0) begin
                s0_TVALID = 1'b1;
                s0_TDATA  = {$urandom(), $urandom()};
            end else begin
                s0_TVALID = 1'b0;
            end
            in0_V_data_V_TREADY = 1'b1;
            in1_V_data_V_TREADY = 1'b1;
            step();
        end
        s0_TVALID = 1'b0;
        s1_TVALID = 1'b0;
        step(); step();
        sb_en = 1'b0;
        check("rand_q0_empty", 64'(q0.size()), 64'd0);
        check("rand_q1_empty", 64'(q1.size()), 64'd0);
        check("rand_skew_err", 64'(skew_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
